avg_pool_controller: RTL and testbench

Sequences one average_pooling datapath (2x2 window, stride 2) across a multi-channel input feature map (IFM).
- Generates four read addresses per window for a 4-read-port IFM buffer.
- Drives pool_enable aligned with the returned data.
- Tracks pooling pipeline latency and issues one output feature map (OFM) write per window.
- Sits between the layer-level scheduler (start/done) and the IFM buffer, pooling unit and OFM buffer. Pixel data does not pass through this block.

---
 rtl/avg_pool_controller.sv | 180 ++++++++++++++++++
 tb/tb_avg_pool_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_pool_controller.sv
// Sequencer for a 2x2/stride-2 average pooling datapath: walks every window of a
// multi-channel IFM, issues 4-port reads, and times the matching OFM writes.
module avg_pool_controller #(
   parameter int IFM_SIZE       = 28,
   parameter int IFM_DEPTH      = 6,
   parameter int ADDR_WIDTH     = 13,
   parameter int OFM_ADDR_WIDTH = 11,
   parameter int RD_LATENCY     = 1,
   parameter int POOL_LATENCY   = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      rd_en,
   output logic [ADDR_WIDTH-1:0]     rd_addr_1,
   output logic [ADDR_WIDTH-1:0]     rd_addr_2,
   output logic [ADDR_WIDTH-1:0]     rd_addr_3,
   output logic [ADDR_WIDTH-1:0]     rd_addr_4,
   output logic                      pool_enable,
   output logic                      ofm_wr_en,
   output logic [OFM_ADDR_WIDTH-1:0] ofm_wr_addr
);

   localparam int HALF  = IFM_SIZE / 2;
   localparam int POS_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int CH_W  = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;

   localparam logic [POS_W-1:0]      POS_MAX  = POS_W'(HALF - 1);
   localparam logic [CH_W-1:0]       CH_MAX   = CH_W'(IFM_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PLANE    = ADDR_WIDTH'(IFM_SIZE * IFM_SIZE);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(2 * IFM_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LINE     = ADDR_WIDTH'(IFM_SIZE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [POS_W-1:0]          col_q, col_d;
   logic [POS_W-1:0]          row_q, row_d;
   logic [CH_W-1:0]           ch_q, ch_d;
   logic                      rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0]     addr1_q, addr1_d;
   logic [ADDR_WIDTH-1:0]     addr2_q, addr2_d;
   logic [ADDR_WIDTH-1:0]     addr3_q, addr3_d;
   logic [ADDR_WIDTH-1:0]     addr4_q, addr4_d;
   logic [RD_LATENCY-1:0]     pool_sr_q, pool_sr_d;
   logic [POOL_LATENCY-1:0]   wr_sr_q, wr_sr_d;
   logic [OFM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic                      last_win;
   logic [ADDR_WIDTH-1:0]     base;

   assign last_win = (col_q == POS_MAX) && (row_q == POS_MAX) && (ch_q == CH_MAX);

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      ch_d      = ch_q;
      rd_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;

      // Delay lines shift every cycle; the pooling pipeline never stalls.
      pool_sr_d = (pool_sr_q << 1) | RD_LATENCY'(rd_en_q);
      wr_sr_d   = (wr_sr_q << 1) | POOL_LATENCY'(pool_sr_q[RD_LATENCY-1]);

      if (state_q == S_IDLE) begin
         wr_addr_d = '0;
      end else if (wr_sr_q[POOL_LATENCY-1]) begin
         wr_addr_d = wr_addr_q + 1'b1;
      end

      // Counters always name the window whose addresses are on the bus this cycle.
      unique case (state_q)
         S_IDLE: begin
            col_d = '0;
            row_d = '0;
            ch_d  = '0;
            if (start) begin
               state_d = S_RUN;
               rd_en_d = 1'b1;
            end
         end
         S_RUN: begin
            if (last_win) begin
               state_d = S_DRAIN;
               col_d   = '0;
               row_d   = '0;
               ch_d    = '0;
            end else begin
               rd_en_d = 1'b1;
               if (col_q == POS_MAX) begin
                  col_d = '0;
                  if (row_q == POS_MAX) begin
                     row_d = '0;
                     ch_d  = ch_q + 1'b1;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            // Leave once the write going out this cycle is the last one pending.
            if ((pool_sr_d == '0) && (wr_sr_d == '0)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      base = ADDR_WIDTH'(ch_d) * PLANE + ADDR_WIDTH'(row_d) * ROW_STEP
           + (ADDR_WIDTH'(col_d) << 1);

      addr1_d = addr1_q;
      addr2_d = addr2_q;
      addr3_d = addr3_q;
      addr4_d = addr4_q;
      if (rd_en_d) begin
         addr1_d = base;
         addr2_d = base + 1'b1;
         addr3_d = base + LINE;
         addr4_d = base + LINE + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         ch_q      <= '0;
         rd_en_q   <= 1'b0;
         addr1_q   <= '0;
         addr2_q   <= '0;
         addr3_q   <= '0;
         addr4_q   <= '0;
         pool_sr_q <= '0;
         wr_sr_q   <= '0;
         wr_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         ch_q      <= ch_d;
         rd_en_q   <= rd_en_d;
         addr1_q   <= addr1_d;
         addr2_q   <= addr2_d;
         addr3_q   <= addr3_d;
         addr4_q   <= addr4_d;
         pool_sr_q <= pool_sr_d;
         wr_sr_q   <= wr_sr_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign rd_en       = rd_en_q;
   assign rd_addr_1   = addr1_q;
   assign rd_addr_2   = addr2_q;
   assign rd_addr_3   = addr3_q;
   assign rd_addr_4   = addr4_q;
   assign pool_enable = pool_sr_q[RD_LATENCY-1];
   assign ofm_wr_en   = wr_sr_q[POOL_LATENCY-1];
   assign ofm_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_avg_pool_controller.sv
// Bench for avg_pool_controller: a 4x4x2 instance with an IFM buffer and pooling
// model around it, plus a 2x2x1 instance for the single-window case.
module tb_avg_pool_controller;

   localparam int SA  = 4;
   localparam int DA  = 2;
   localparam int NA  = (SA / 2) * (SA / 2) * DA;
   localparam int RDL = 1;
   localparam int PL  = 3;
   localparam int LAT = RDL + PL;

   logic clk = 1'b0;
   logic reset;
   logic start_a, start_b;

   logic        busy_a, done_a, rd_en_a, pe_a, wr_a;
   logic [12:0] a1_a, a2_a, a3_a, a4_a;
   logic [10:0] wa_a;
   logic        busy_b, done_b, rd_en_b, pe_b, wr_b;
   logic [12:0] a1_b, a2_b, a3_b, a4_b;
   logic [10:0] wa_b;

   int compared   = 0;
   int mismatched = 0;

   int ifm [SA*SA*DA];
   int rd_q [4];
   int pipe [3];

   always #5 clk = ~clk;

   avg_pool_controller #(.IFM_SIZE(SA), .IFM_DEPTH(DA)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
      .rd_en(rd_en_a), .rd_addr_1(a1_a), .rd_addr_2(a2_a), .rd_addr_3(a3_a),
      .rd_addr_4(a4_a), .pool_enable(pe_a), .ofm_wr_en(wr_a), .ofm_wr_addr(wa_a)
   );

   avg_pool_controller #(.IFM_SIZE(2), .IFM_DEPTH(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr_1(a1_b), .rd_addr_2(a2_b), .rd_addr_3(a3_b),
      .rd_addr_4(a4_b), .pool_enable(pe_b), .ofm_wr_en(wr_b), .ofm_wr_addr(wa_b)
   );

   // IFM buffer (1-cycle read) and a pooling unit with 3-cycle latency
   always @(posedge clk) begin
      if (rd_en_a) begin
         rd_q[0] <= (int'(a1_a) < SA*SA*DA) ? ifm[a1_a] : -1;
         rd_q[1] <= (int'(a2_a) < SA*SA*DA) ? ifm[a2_a] : -1;
         rd_q[2] <= (int'(a3_a) < SA*SA*DA) ? ifm[a3_a] : -1;
         rd_q[3] <= (int'(a4_a) < SA*SA*DA) ? ifm[a4_a] : -1;
      end
      pipe[0] <= pe_a ? (rd_q[0] + rd_q[1] + rd_q[2] + rd_q[3]) / 4 : -7;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
   end

   function automatic int win_base(input int k);
      int ch, row, col;
      ch  = k / ((SA / 2) * (SA / 2));
      row = (k % ((SA / 2) * (SA / 2))) / (SA / 2);
      col = k % (SA / 2);
      return ch * SA * SA + 2 * row * SA + 2 * col;
   endfunction

   task automatic test_reset();
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({busy_a, done_a, rd_en_a, pe_a, wr_a} !== 5'b0 || wa_a !== 11'd0 ||
          {a1_a, a2_a, a3_a, a4_a} !== 52'd0) begin
         mismatched++;
         $display("FAIL reset_a: busy=%b done=%b rd=%b pe=%b wr=%b wa=%0d a1=%0d, required all 0",
                  busy_a, done_a, rd_en_a, pe_a, wr_a, wa_a, a1_a);
      end
      compared++;
      if ({busy_b, done_b, rd_en_b, pe_b, wr_b} !== 5'b0 || wa_b !== 11'd0) begin
         mismatched++;
         $display("FAIL reset_b: busy=%b done=%b rd=%b wr=%b, required all 0",
                  busy_b, done_b, rd_en_b, wr_b);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Full layer on dut_a; start re-pulsed in cycle `glitch` (0 = never), which must be ignored.
   task automatic test_layer(input int glitch);
      int exp_base;
      int k;
      int exp_avg;
      for (int i = 0; i < SA*SA*DA; i++) ifm[i] = $urandom_range(255, 0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      start_a = 1'b1;
      for (int t = 1; t <= NA + LAT + 3; t++) begin
         @(negedge clk);
         start_a = (t == glitch);
         exp_base = win_base((t <= NA) ? t - 1 : NA - 1);
         compared++;
         if (rd_en_a !== (t <= NA)) begin
            mismatched++;
            $display("FAIL layer_rd_en cyc%0d: got %b, required %b", t, rd_en_a, t <= NA);
         end
         compared++;
         if (int'(a1_a) != exp_base || int'(a2_a) != exp_base + 1 ||
             int'(a3_a) != exp_base + SA || int'(a4_a) != exp_base + SA + 1) begin
            mismatched++;
            $display("FAIL layer_addr cyc%0d: got %0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d",
                     t, a1_a, a2_a, a3_a, a4_a, exp_base, exp_base + 1, exp_base + SA,
                     exp_base + SA + 1);
         end
         compared++;
         if (pe_a !== (t > RDL && t <= NA + RDL)) begin
            mismatched++;
            $display("FAIL layer_pool_en cyc%0d: got %b", t, pe_a);
         end
         compared++;
         if (wr_a !== (t > LAT && t <= NA + LAT)) begin
            mismatched++;
            $display("FAIL layer_wr_en cyc%0d: got %b", t, wr_a);
         end
         compared++;
         if (done_a !== (t == NA + LAT + 1) || busy_a !== (t <= NA + LAT + 1)) begin
            mismatched++;
            $display("FAIL layer_done_busy cyc%0d: got done=%b busy=%b required %b %b",
                     t, done_a, busy_a, t == NA + LAT + 1, t <= NA + LAT + 1);
         end
         if (t > LAT && t <= NA + LAT) begin
            k = t - LAT - 1;
            exp_avg = (ifm[win_base(k)] + ifm[win_base(k) + 1] + ifm[win_base(k) + SA] +
                       ifm[win_base(k) + SA + 1]) / 4;
            compared++;
            if (int'(wa_a) != k) begin
               mismatched++;
               $display("FAIL layer_wr_addr cyc%0d: got %0d required %0d", t, wa_a, k);
            end
            compared++;
            if (pipe[2] != exp_avg) begin
               mismatched++;
               $display("FAIL layer_pool_data win%0d: got %0d required %0d", k, pipe[2], exp_avg);
            end
         end
      end
   endtask

   // start held high through DONE starts a second layer right after one IDLE cycle
   task automatic test_back_to_back();
      int n_wr = 0, n_done = 0, rd_start2 = -1;
      start_a = 1'b1;
      for (int t = 1; t <= 2 * (NA + LAT + 2) + 2; t++) begin
         @(negedge clk);
         if (t == NA + LAT + 1 + 2) start_a = 1'b0;
         if (t == NA + LAT + 2) begin
            compared++;
            if (busy_a !== 1'b0) begin
               mismatched++;
               $display("FAIL b2b_idle_gap cyc%0d: busy got %b required 0", t, busy_a);
            end
         end
         if (rd_en_a && t > NA && rd_start2 < 0) begin
            rd_start2 = t;
            compared++;
            if (a1_a !== 13'd0) begin
               mismatched++;
               $display("FAIL b2b_restart_addr: got %0d required 0", a1_a);
            end
         end
         if (wr_a) begin
            compared++;
            if (int'(wa_a) != n_wr % NA) begin
               mismatched++;
               $display("FAIL b2b_wr_addr: got %0d required %0d", wa_a, n_wr % NA);
            end
            n_wr++;
         end
         if (done_a) n_done++;
      end
      compared++;
      if (rd_start2 != NA + LAT + 3) begin
         mismatched++;
         $display("FAIL b2b_second_start: got cyc%0d required cyc%0d", rd_start2, NA + LAT + 3);
      end
      compared++;
      if (n_wr != 2 * NA || n_done != 2) begin
         mismatched++;
         $display("FAIL b2b_counts: writes=%0d dones=%0d required %0d 2", n_wr, n_done, 2 * NA);
      end
   endtask

   // reset in cycle 7 of a layer: outputs clear at once and no stale writes follow
   task automatic test_reset_midrun();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      #1;
      compared++;
      if ({busy_a, done_a, rd_en_a, pe_a, wr_a} !== 5'b0 || wa_a !== 11'd0 ||
          {a1_a, a2_a, a3_a, a4_a} !== 52'd0) begin
         mismatched++;
         $display("FAIL midrun_reset: busy=%b rd=%b pe=%b wr=%b wa=%0d a1=%0d, required all 0",
                  busy_a, rd_en_a, pe_a, wr_a, wa_a, a1_a);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int t = 0; t < $urandom_range(10, 6); t++) begin
         @(negedge clk);
         compared++;
         if (wr_a !== 1'b0 || busy_a !== 1'b0 || rd_en_a !== 1'b0) begin
            mismatched++;
            $display("FAIL midrun_quiet: wr=%b busy=%b rd=%b, required 0", wr_a, busy_a, rd_en_a);
         end
      end
   endtask

   task automatic test_degenerate();
      start_b = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         @(negedge clk);
         start_b = 1'b0;
         compared++;
         if (rd_en_b !== (t == 1) || pe_b !== (t == 2) || wr_b !== (t == 5) ||
             done_b !== (t == 6) || busy_b !== (t <= 6)) begin
            mismatched++;
            $display("FAIL degen_ctrl cyc%0d: rd=%b pe=%b wr=%b done=%b busy=%b", t, rd_en_b,
                     pe_b, wr_b, done_b, busy_b);
         end
         compared++;
         if (a1_b !== 13'd0 || a2_b !== 13'd1 || a3_b !== 13'd2 || a4_b !== 13'd3) begin
            mismatched++;
            $display("FAIL degen_addr cyc%0d: got %0d,%0d,%0d,%0d required 0,1,2,3", t, a1_b,
                     a2_b, a3_b, a4_b);
         end
         if (t == 5) begin
            compared++;
            if (wa_b !== 11'd0) begin
               mismatched++;
               $display("FAIL degen_wr_addr: got %0d required 0", wa_b);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_layer(0);
      test_layer(6);
      test_layer($urandom_range(NA, 2));
      test_back_to_back();
      test_reset_midrun();
      test_layer(0);
      test_degenerate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
